// File: rtl/sd_spi_port.sv
// CPU-bus SPI master for the SD card slot: single-byte mode-0 transfers, programmable SCK
// divider, and a burst mode that clocks out N bytes of 0xFF for card initialisation.
module sd_spi_port #(
    parameter int unsigned DIV_RESET = 62
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       n_wr,
    input  logic       n_rd,
    input  logic [2:0] regAddr,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    output logic       sdCS,
    output logic       sdSCLK,
    output logic       sdMOSI,
    input  logic       sdMISO,
    output logic       driveLED
);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } state_e;

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrDiv    = 3'd2;
    localparam logic [2:0] AddrBurst  = 3'd3;

    state_e     r_state;
    state_e     w_state_next;

    logic       r_n_wr_prev;
    logic       r_n_rd_prev;
    logic [7:0] r_data;
    logic [7:0] r_div;
    logic [7:0] r_div_lat;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [8:0] r_count;
    logic       r_cs;
    logic       r_drop;

    logic       w_wr_edge;
    logic       w_rd_edge;
    logic       w_busy;
    logic       w_phase_end;
    logic       w_start;
    logic       w_wr_blocked;
    logic       w_low_end;
    logic       w_high_end;
    logic       w_more;

    // Strobes act once, on the first low cycle after a high one.
    assign w_wr_edge = !n_wr && r_n_wr_prev;
    assign w_rd_edge = !n_rd && r_n_rd_prev;

    assign w_busy       = (r_state != StIdle);
    assign w_phase_end  = (r_cnt == 8'd0);
    assign w_low_end    = (r_state == StLow) && w_phase_end;
    assign w_high_end   = (r_state == StHigh) && w_phase_end;
    assign w_more       = (r_count != 9'd1);
    assign w_start      = w_wr_edge && !w_busy
                          && ((regAddr == AddrData) || (regAddr == AddrBurst));
    assign w_wr_blocked = w_wr_edge && w_busy
                          && ((regAddr == AddrData) || (regAddr == AddrBurst)
                              || (regAddr == AddrDiv));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StLow;
                end
            end
            StLow: begin
                if (w_phase_end) begin
                    w_state_next = StHigh;
                end
            end
            StHigh: begin
                if (w_phase_end) begin
                    if (r_bit != 3'd0 || w_more) begin
                        w_state_next = StLow;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n_wr_prev <= 1'b1;
            r_n_rd_prev <= 1'b1;
            r_data      <= 8'hFF;
            r_div       <= 8'(DIV_RESET);
            r_div_lat   <= 8'(DIV_RESET);
            r_cnt       <= 8'd0;
            r_bit       <= 3'd7;
            r_tx        <= 8'hFF;
            r_rx        <= 8'hFF;
            r_count     <= 9'd0;
            r_cs        <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_n_wr_prev <= n_wr;
            r_n_rd_prev <= n_rd;

            // Phase timer runs off the divider captured at transfer start.
            if (w_start) begin
                r_cnt     <= r_div;
                r_div_lat <= r_div;
            end else if (w_busy) begin
                if (w_phase_end) begin
                    r_cnt <= r_div_lat;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            if (w_low_end) begin
                r_rx <= {r_rx[6:0], sdMISO};
            end

            if (w_high_end) begin
                if (r_bit != 3'd0) begin
                    r_bit <= r_bit - 3'd1;
                    r_tx  <= {r_tx[6:0], 1'b1};
                end else begin
                    r_data  <= r_rx;
                    r_count <= r_count - 9'd1;
                    r_bit   <= 3'd7;
                    r_tx    <= 8'hFF;
                end
            end

            if (w_rd_edge && (regAddr == AddrStatus)) begin
                r_drop <= 1'b0;
            end

            if (w_wr_blocked) begin
                r_drop <= 1'b1;
            end

            if (w_wr_edge) begin
                unique case (regAddr)
                    AddrData: begin
                        if (!w_busy) begin
                            r_tx    <= dataIn;
                            r_count <= 9'd1;
                            r_bit   <= 3'd7;
                        end
                    end
                    AddrStatus: r_cs <= dataIn[0];
                    AddrDiv: begin
                        if (!w_busy) begin
                            r_div <= dataIn;
                        end
                    end
                    AddrBurst: begin
                        if (!w_busy) begin
                            r_tx    <= 8'hFF;
                            r_bit   <= 3'd7;
                            r_count <= (dataIn == 8'd0) ? 9'd256 : {1'b0, dataIn};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dataOut = 8'hFF;
        unique case (regAddr)
            AddrData:   dataOut = r_data;
            AddrStatus: dataOut = {5'b00000, r_cs, r_drop, w_busy};
            AddrDiv:    dataOut = r_div;
            AddrBurst:  dataOut = r_count[7:0];
            default:    dataOut = 8'hFF;
        endcase
    end

    assign sdCS     = !r_cs;
    assign driveLED = r_cs;
    assign sdSCLK   = (r_state == StHigh);
    assign sdMOSI   = (r_state == StIdle) ? 1'b1 : r_tx[7];

endmodule

// File: tb/tb_sd_spi_port.sv
// Directed self-checking bench for sd_spi_port: register map, byte/burst timing,
// busy-write drop handling and reset during a transfer.
module tb_sd_spi_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       n_wr = 1'b1;
    logic       n_rd = 1'b1;
    logic [2:0] regAddr = 3'd0;
    logic [7:0] dataIn = 8'd0;
    logic [7:0] dataOut;
    logic       sdCS;
    logic       sdSCLK;
    logic       sdMOSI;
    logic       tb_miso;
    logic       driveLED;

    int n_checks = 0;
    int n_fail = 0;

    // Bus-side monitors; tasks only read these and record base values.
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    int         mosi0_cnt = 0;
    int         cs_low_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;
    longint     last_rise_t = 0;
    longint     prev_rise_t = 0;

    logic [7:0] miso_byte = 8'hFF;
    int         miso_base = 0;
    int         miso_idx;

    sd_spi_port #(.DIV_RESET(62)) dut (
        .clk      (clk),
        .reset    (reset),
        .n_wr     (n_wr),
        .n_rd     (n_rd),
        .regAddr  (regAddr),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .sdCS     (sdCS),
        .sdSCLK   (sdSCLK),
        .sdMOSI   (sdMOSI),
        .sdMISO   (tb_miso),
        .driveLED (driveLED)
    );

    always #5 clk = ~clk;

    always @(posedge sdSCLK) begin
        rise_cnt    <= rise_cnt + 1;
        mosi_cap    <= {mosi_cap[6:0], sdMOSI};
        prev_rise_t <= last_rise_t;
        last_rise_t <= $time;
        if (sdMOSI === 1'b0) mosi0_cnt <= mosi0_cnt + 1;
    end

    always @(negedge sdSCLK) fall_cnt <= fall_cnt + 1;

    always @(posedge clk) if (sdCS === 1'b0) cs_low_cnt <= cs_low_cnt + 1;

    // Mode-0 slave: bit 7 ready before the first rise, next bit after each fall.
    always_comb begin
        miso_idx = fall_cnt - miso_base;
        tb_miso  = 1'b1;
        if (miso_idx >= 0 && miso_idx < 8) tb_miso = miso_byte[3'(7 - miso_idx)];
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        regAddr = a;
        dataIn  = d;
        n_wr    = 1'b0;
        @(negedge clk);
        n_wr = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        regAddr = a;
        n_rd    = 1'b0;
        #1;
        d = dataOut;
        @(negedge clk);
        n_rd = 1'b1;
    endtask

    // Counts cycles (from now) for which STATUS.busy reads 1, bounded by limit.
    task automatic wait_busy(input int limit, output int cycles);
        regAddr = 3'd1;
        #1;
        cycles = 0;
        while (dataOut[0] === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({sdCS, sdSCLK, sdMOSI, driveLED} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_pins: got %b expected 1010", {sdCS, sdSCLK, sdMOSI, driveLED});
        end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", v); end
        rd(3'd2, v);
        n_checks++;
        if (v !== 8'd62) begin n_fail++; $display("FAIL reset_div: got %0d expected 62", v); end
        rd(3'd0, v);
        n_checks++;
        if (v !== 8'hFF) begin n_fail++; $display("FAIL reset_data: got %h expected ff", v); end
        rd(3'd3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_burst: got %h expected 00", v); end
        wr(3'd6, 8'h12);
        rd(3'd6, v);
        n_checks++;
        if (v !== 8'hFF) begin n_fail++; $display("FAIL unused_reg: got %h expected ff", v); end
    endtask

    task automatic test_single_byte();
        logic [7:0] v;
        int         cyc;
        int         rbase;
        wr(3'd2, 8'd0);
        wr(3'd1, 8'd1);
        n_checks++;
        if ({sdCS, driveLED} !== 2'b01) begin
            n_fail++;
            $display("FAIL cs_assert: got %b expected 01", {sdCS, driveLED});
        end
        miso_byte = 8'h3C;
        miso_base = fall_cnt;
        rbase     = rise_cnt;
        wr(3'd0, 8'hA5);
        n_checks++;
        if (sdMOSI !== 1'b1) begin n_fail++; $display("FAIL first_mosi: got %b expected 1", sdMOSI); end
        wait_busy(100, cyc);
        n_checks++;
        if (cyc !== 16) begin n_fail++; $display("FAIL single_busy: got %0d expected 16", cyc); end
        n_checks++;
        if (rise_cnt - rbase !== 8) begin
            n_fail++;
            $display("FAIL single_rises: got %0d expected 8", rise_cnt - rbase);
        end
        n_checks++;
        if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL single_mosi: got %h expected a5", mosi_cap); end
        rd(3'd0, v);
        n_checks++;
        if (v !== 8'h3C) begin n_fail++; $display("FAIL single_rx: got %h expected 3c", v); end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL single_status: got %h expected 04", v); end
    endtask

    task automatic test_divider();
        logic [7:0] v;
        int         cyc;
        int         c;
        wr(3'd2, 8'd3);
        wr(3'd0, 8'h00);
        c = 0;
        while (sdSCLK !== 1'b1 && c < 100) begin
            c++;
            @(negedge clk);
        end
        n_checks++;
        if (c !== 4) begin n_fail++; $display("FAIL first_rise: got %0d expected 4", c); end
        wr(3'd2, 8'd0);
        wait_busy(200, cyc);
        n_checks++;
        if (cyc !== 58) begin n_fail++; $display("FAIL div_busy: got %0d expected 58", cyc); end
        n_checks++;
        if (last_rise_t - prev_rise_t !== 80) begin
            n_fail++;
            $display("FAIL sck_period: got %0d expected 80", last_rise_t - prev_rise_t);
        end
        rd(3'd2, v);
        n_checks++;
        if (v !== 8'd3) begin n_fail++; $display("FAIL div_kept: got %0d expected 3", v); end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h06) begin n_fail++; $display("FAIL div_drop: got %h expected 06", v); end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL drop_clear: got %h expected 04", v); end
    endtask

    task automatic test_init_burst();
        logic [7:0] v;
        int         cyc;
        int         rbase;
        int         m0base;
        int         csbase;
        wr(3'd1, 8'd0);
        wr(3'd2, 8'd62);
        rbase  = rise_cnt;
        m0base = mosi0_cnt;
        csbase = cs_low_cnt;
        wr(3'd3, 8'd10);
        wait_busy(20000, cyc);
        n_checks++;
        if (cyc !== 10080) begin n_fail++; $display("FAIL burst_busy: got %0d expected 10080", cyc); end
        n_checks++;
        if (rise_cnt - rbase !== 80) begin
            n_fail++;
            $display("FAIL burst_rises: got %0d expected 80", rise_cnt - rbase);
        end
        n_checks++;
        if (mosi0_cnt - m0base !== 0) begin
            n_fail++;
            $display("FAIL burst_mosi: got %0d zero bits expected 0", mosi0_cnt - m0base);
        end
        n_checks++;
        if (cs_low_cnt - csbase !== 0) begin
            n_fail++;
            $display("FAIL burst_cs: got %0d low cycles expected 0", cs_low_cnt - csbase);
        end
        rd(3'd3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL burst_count: got %h expected 00", v); end
        rd(3'd0, v);
        n_checks++;
        if (v !== 8'hFF) begin n_fail++; $display("FAIL burst_rx: got %h expected ff", v); end
    endtask

    task automatic test_burst_256();
        int cyc;
        wr(3'd2, 8'd0);
        wr(3'd3, 8'd0);
        regAddr = 3'd3;
        #1;
        n_checks++;
        if (dataOut !== 8'h00) begin n_fail++; $display("FAIL b256_start: got %h expected 00", dataOut); end
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (dataOut !== 8'hFF) begin n_fail++; $display("FAIL b256_count: got %h expected ff", dataOut); end
        wait_busy(5000, cyc);
        n_checks++;
        if (cyc !== 4076) begin n_fail++; $display("FAIL b256_busy: got %0d expected 4076", cyc); end
    endtask

    task automatic test_busy_write();
        logic [7:0] v;
        int         cyc;
        int         rbase;
        wr(3'd1, 8'd1);
        rbase = rise_cnt;
        wr(3'd0, 8'h11);
        repeat (2) @(negedge clk);
        wr(3'd0, 8'h22);
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h07) begin n_fail++; $display("FAIL busy_status1: got %h expected 07", v); end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h05) begin n_fail++; $display("FAIL busy_status2: got %h expected 05", v); end
        wait_busy(100, cyc);
        n_checks++;
        if (mosi_cap !== 8'h11 || rise_cnt - rbase !== 8) begin
            n_fail++;
            $display("FAIL busy_tx: got %h/%0d rises expected 11/8", mosi_cap, rise_cnt - rbase);
        end
        rd(3'd1, v);
        n_checks++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL busy_status3: got %h expected 04", v); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] v;
        int         cyc;
        int         rbase;
        int         c;
        rbase = rise_cnt;
        wr(3'd0, 8'hC3);
        c = 0;
        while (rise_cnt - rbase < 3 && c < 200) begin
            c++;
            @(negedge clk);
        end
        n_checks++;
        if (rise_cnt - rbase !== 3) begin
            n_fail++;
            $display("FAIL mid_rises: got %0d expected 3", rise_cnt - rbase);
        end
        reset = 1'b1;
        @(negedge clk);
        regAddr = 3'd1;
        #1;
        n_checks++;
        if ({sdSCLK, sdMOSI, sdCS, dataOut[0]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL mid_reset_pins: got %b expected 0110", {sdSCLK, sdMOSI, sdCS, dataOut[0]});
        end
        regAddr = 3'd0;
        #1;
        n_checks++;
        if (dataOut !== 8'hFF) begin n_fail++; $display("FAIL mid_reset_data: got %h expected ff", dataOut); end
        reset = 1'b0;
        wr(3'd2, 8'd0);
        wr(3'd1, 8'd1);
        miso_byte = 8'h96;
        miso_base = fall_cnt;
        rbase     = rise_cnt;
        wr(3'd0, 8'h5A);
        n_checks++;
        if (sdMOSI !== 1'b0) begin n_fail++; $display("FAIL post_first_mosi: got %b expected 0", sdMOSI); end
        wait_busy(100, cyc);
        n_checks++;
        if (cyc !== 16 || mosi_cap !== 8'h5A || rise_cnt - rbase !== 8) begin
            n_fail++;
            $display("FAIL post_tx: got %0d/%h/%0d expected 16/5a/8", cyc, mosi_cap, rise_cnt - rbase);
        end
        rd(3'd0, v);
        n_checks++;
        if (v !== 8'h96) begin n_fail++; $display("FAIL post_rx: got %h expected 96", v); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_divider();
        test_init_burst();
        test_burst_256();
        test_busy_write();
        test_reset_mid_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
